mouse_cmd_scheduler: RTL and testbench
======================================

# mouse_cmd_scheduler

Shares the PS/2 mouse link's transmitter/receiver pair between two command requesters: the processor bus port (CPU) and the power-up configuration engine (CFG). It arbitrates round-robin, sends a command byte and an optional argument byte, and waits for the device acknowledge on each. It retries on resend, times out on silence, and reports per-requester completion and error status. It sits between the requesters and the mouse transmitter/receiver, and asserts link ownership so the master state machine pauses streaming.

## Interface
- ACK_TIMEOUT, 2_000_000: cycles allowed for BYTE_SENT, and separately for the ACK (20 ms at 100 MHz).
- MAX_RETRIES, 3: resend attempts per byte after a 0xFE or receive error.
- CLK  in  1  system clock; one clock domain.
- RESET  in  1  synchronous, active-high.
- CPU_REQ, CFG_REQ  in  1  request; held high until the matching DONE.
- CPU_CMD, CFG_CMD  in  8  command byte.
- CPU_ARG, CFG_ARG  in  8  argument byte.
- CPU_HAS_ARG, CFG_HAS_ARG  in  1  send the argument byte after the command is acknowledged.
- CPU_DONE, CFG_DONE  out  1  one-cycle completion pulse.
- CPU_ERR, CFG_ERR  out  2  status, valid in the DONE cycle and held until the next DONE on that requester. Codes: 00 ok, 01 timeout, 10 device error (0xFC), 11 retries exhausted.
- LINK_OWNED  out  1  high from grant through REPORT.
- SEND_BYTE  out  1  one-cycle pulse to the transmitter.
- BYTE_TO_SEND  out  8  byte to transmit; stable from SEND until WAIT_ACK exits.
- BYTE_SENT  in  1  transmitter completion.
- READ_ENABLE  out  1  high only in WAIT_ACK.
- BYTE_READ  in  8  received byte.
- BYTE_ERROR_CODE  in  2  receiver error; non-zero means a bad frame.
- BYTE_READY  in  1  received-byte strobe.

## Operation
- States: IDLE, SEND, WAIT_SENT, WAIT_ACK, REPORT.
- Register `phase` selects CMD (0) or ARG (1). Register `owner` records CPU or CFG.
- **IDLE**
  - Any REQ: grant, latch CMD, ARG and HAS_ARG, set phase=0, retries=0, go to SEND.
  - Both REQ: grant the requester not granted last. The last-grant pointer resets to CPU, so CFG wins the first tie.
- **SEND**: SEND_BYTE=1 for exactly this cycle, with BYTE_TO_SEND = phase ? ARG : CMD. Clear the timer; go to WAIT_SENT.
- **WAIT_SENT**
  - BYTE_SENT: go to WAIT_ACK and clear the timer.
  - Timer reaches ACK_TIMEOUT-1: REPORT with 01.
- **WAIT_ACK**, checked on BYTE_READY in this priority order:
  - ERROR_CODE≠0 or byte 0xFE: if retries<MAX_RETRIES, increment retries and go to SEND (same byte). Otherwise REPORT with 11.
  - 0xFC: REPORT with 10.
  - 0xFA: if phase=0 and HAS_ARG, set phase=1, retries=0, go to SEND. Otherwise REPORT with 00.
  - Any other byte is stray stream data: ignore it; the timer keeps running.
  - Timeout (ACK_TIMEOUT cycles without a terminating byte): REPORT with 01.
- **REPORT**: pulse the owner's DONE, load the owner's ERR, update the last-grant pointer, return to IDLE.
- Requester inputs are sampled only at grant. Dropping REQ mid-command does not abort the command.
- Reset values: all outputs 0, ERR=00, state IDLE, last-grant=CPU.

## Timing
- REQ seen high in IDLE at edge N: SEND_BYTE is high in cycle N+1.
- BYTE_SENT at edge M: READ_ENABLE is high from M+1.
- Terminating ACK at edge K: DONE is high in cycle K+1. The next grant is no earlier than K+2, since REPORT always passes through IDLE.
- The timer is a counter of $clog2(ACK_TIMEOUT+1) bits that saturates. It is cleared on entry to WAIT_SENT and to WAIT_ACK.
- BYTE_READY arriving in the same cycle as the timeout terminal count: the byte wins.
- RESET mid-command returns to IDLE next cycle. No DONE is generated and no further SEND_BYTE is issued. Any transmitter frame already in flight is the transmitter's concern.

## Structure
- Shared package mouse_pkg holds:
  - ACK constants MOUSE_ACK=8'hFA, MOUSE_RESEND=8'hFE, MOUSE_ERROR=8'hFC;
  - error-code localparams ERR_OK, ERR_TIMEOUT, ERR_DEVICE, ERR_RETRY;
  - the state encoding.
- One sub-module, mouse_timeout_ctr (clear, enable, terminal-count output), parameterised by ACK_TIMEOUT.
- Arbitration and the FSM stay in the top module.

## Test plan
- CPU_REQ with CMD=8'hF4 and no argument; model returns BYTE_SENT, then 0xFA → one SEND_BYTE with BYTE_TO_SEND=F4; CPU_DONE pulses with CPU_ERR=00 one cycle after the ACK.
- CFG_REQ with CMD=8'hF3, ARG=8'd200, HAS_ARG=1 → sends F3, waits for FA, sends C8, waits for FA; CFG_DONE with 00. Both grants show LINK_OWNED high throughout.
- CPU_REQ and CFG_REQ rise in the same cycle after reset → CFG served first, then CPU. On a repeat tie the grants alternate.
- Model answers 0xFE four times (MAX_RETRIES=3) → exactly four SEND_BYTE pulses, then DONE with ERR=11. A variant with a stray 0x08 before the FA → the stray byte is ignored and the command completes with 00.
- No BYTE_READY after BYTE_SENT (ACK_TIMEOUT set to 100 for simulation) → DONE exactly 100 cycles after WAIT_ACK entry, with ERR=01. Model answers 0xFC → ERR=10.
- RESET asserted in WAIT_ACK → the next cycle shows IDLE, with all outputs 0 and no DONE. A fresh request afterwards completes normally.

Source files
------------

// File: rtl/mouse_pkg.sv
// Shared constants and encodings for the PS/2 mouse command path.
package mouse_pkg;

  localparam logic [7:0] MOUSE_ACK    = 8'hFA;
  localparam logic [7:0] MOUSE_RESEND = 8'hFE;
  localparam logic [7:0] MOUSE_ERROR  = 8'hFC;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_DEVICE  = 2'b10;
  localparam logic [1:0] ERR_RETRY   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_SENT,
    ST_WAIT_ACK,
    ST_REPORT
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_CFG = 1'b1
  } owner_t;

endpackage

// File: rtl/mouse_timeout_ctr.sv
// Saturating silence timer; terminal flags the last allowed cycle of a wait.
module mouse_timeout_ctr #(
  parameter int ACK_TIMEOUT = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [W-1:0] TC  = W'(ACK_TIMEOUT - 1);
  localparam logic [W-1:0] SAT = W'(ACK_TIMEOUT);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != SAT)) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = enable && (count == TC);

endmodule

// File: rtl/mouse_cmd_scheduler.sv
// Round-robin sharing of the PS/2 mouse link between CPU and CFG command
// requesters, with per-byte acknowledge, resend retry and silence timeout.
module mouse_cmd_scheduler
  import mouse_pkg::*;
#(
  parameter int ACK_TIMEOUT = 2_000_000,
  parameter int MAX_RETRIES = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CPU_REQ,
  input  logic       CFG_REQ,
  input  logic [7:0] CPU_CMD,
  input  logic [7:0] CFG_CMD,
  input  logic [7:0] CPU_ARG,
  input  logic [7:0] CFG_ARG,
  input  logic       CPU_HAS_ARG,
  input  logic       CFG_HAS_ARG,
  output logic       CPU_DONE,
  output logic       CFG_DONE,
  output logic [1:0] CPU_ERR,
  output logic [1:0] CFG_ERR,
  output logic       LINK_OWNED,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY
);

  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRIES);

  state_t        state;
  owner_t        owner;
  owner_t        last_grant;
  logic          phase;
  logic [RW-1:0] retries;
  logic [7:0]    arg_q;
  logic          has_arg_q;

  logic       grant_cfg;
  logic       rx_bad;
  logic       rx_advance;
  logic       fin;
  logic [1:0] fin_code;
  logic       tmr_clear;
  logic       tmr_en;
  logic       tmr_tc;

  mouse_timeout_ctr #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
    .clk      (CLK),
    .rst      (RESET),
    .clear    (tmr_clear),
    .enable   (tmr_en),
    .terminal (tmr_tc)
  );

  // Terminating byte beats the timeout terminal count in the same cycle.
  always_comb begin
    grant_cfg  = CFG_REQ && (!CPU_REQ || (last_grant == OWN_CPU));
    rx_bad     = (BYTE_ERROR_CODE != 2'b00) || (BYTE_READ == MOUSE_RESEND);
    rx_advance = !rx_bad && (BYTE_READ == MOUSE_ACK) && !phase && has_arg_q;
    tmr_clear  = (state == ST_SEND) || ((state == ST_WAIT_SENT) && BYTE_SENT);
    tmr_en     = (state == ST_WAIT_SENT) || (state == ST_WAIT_ACK);
    fin        = 1'b0;
    fin_code   = ERR_OK;
    case (state)
      ST_WAIT_SENT: begin
        if (!BYTE_SENT && tmr_tc) begin
          fin      = 1'b1;
          fin_code = ERR_TIMEOUT;
        end
      end
      ST_WAIT_ACK: begin
        if (BYTE_READY && rx_bad) begin
          if (retries >= RMAX) begin
            fin      = 1'b1;
            fin_code = ERR_RETRY;
          end
        end else if (BYTE_READY && (BYTE_READ == MOUSE_ERROR)) begin
          fin      = 1'b1;
          fin_code = ERR_DEVICE;
        end else if (BYTE_READY && (BYTE_READ == MOUSE_ACK)) begin
          if (!rx_advance) begin
            fin      = 1'b1;
            fin_code = ERR_OK;
          end
        end else if (tmr_tc) begin
          fin      = 1'b1;
          fin_code = ERR_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= ST_IDLE;
      owner        <= OWN_CPU;
      last_grant   <= OWN_CPU;
      phase        <= 1'b0;
      retries      <= '0;
      SEND_BYTE    <= 1'b0;
      BYTE_TO_SEND <= 8'h00;
      READ_ENABLE  <= 1'b0;
      LINK_OWNED   <= 1'b0;
      CPU_DONE     <= 1'b0;
      CFG_DONE     <= 1'b0;
      CPU_ERR      <= ERR_OK;
      CFG_ERR      <= ERR_OK;
    end else begin
      SEND_BYTE <= 1'b0;
      CPU_DONE  <= 1'b0;
      CFG_DONE  <= 1'b0;
      if (fin) begin
        state       <= ST_REPORT;
        READ_ENABLE <= 1'b0;
        if (owner == OWN_CFG) begin
          CFG_DONE <= 1'b1;
          CFG_ERR  <= fin_code;
        end else begin
          CPU_DONE <= 1'b1;
          CPU_ERR  <= fin_code;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (CPU_REQ || CFG_REQ) begin
              state        <= ST_SEND;
              SEND_BYTE    <= 1'b1;
              LINK_OWNED   <= 1'b1;
              phase        <= 1'b0;
              retries      <= '0;
              owner        <= grant_cfg ? OWN_CFG : OWN_CPU;
              BYTE_TO_SEND <= grant_cfg ? CFG_CMD : CPU_CMD;
              arg_q        <= grant_cfg ? CFG_ARG : CPU_ARG;
              has_arg_q    <= grant_cfg ? CFG_HAS_ARG : CPU_HAS_ARG;
            end
          end
          ST_SEND: state <= ST_WAIT_SENT;
          ST_WAIT_SENT: begin
            if (BYTE_SENT) begin
              state       <= ST_WAIT_ACK;
              READ_ENABLE <= 1'b1;
            end
          end
          ST_WAIT_ACK: begin
            if (BYTE_READY && rx_bad) begin
              retries     <= retries + 1'b1;
              state       <= ST_SEND;
              SEND_BYTE   <= 1'b1;
              READ_ENABLE <= 1'b0;
            end else if (BYTE_READY && rx_advance) begin
              phase        <= 1'b1;
              retries      <= '0;
              BYTE_TO_SEND <= arg_q;
              state        <= ST_SEND;
              SEND_BYTE    <= 1'b1;
              READ_ENABLE  <= 1'b0;
            end
          end
          ST_REPORT: begin
            state      <= ST_IDLE;
            LINK_OWNED <= 1'b0;
            last_grant <= owner;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mouse_cmd_scheduler.sv
// Scoreboard bench for mouse_cmd_scheduler with a scripted PS/2 device model.
module tb_mouse_cmd_scheduler;

  localparam int ACK_TO = 100;

  typedef enum int {T_ACK, T_RESEND, T_BADFRAME, T_DEVERR, T_STRAY, T_SILENT, T_NOSENT} tok_t;
  typedef enum int {K_BYTE, K_ACK_TO, K_SENT_TO} kind_t;

  typedef struct {
    bit          is_cfg;
    logic [1:0]  err;
    kind_t       kind;
    int          nbytes;
    logic [63:0] bytes;
  } sb_item_t;

  logic       clk;
  logic       RESET;
  logic       CPU_REQ, CFG_REQ;
  logic [7:0] CPU_CMD, CFG_CMD, CPU_ARG, CFG_ARG;
  logic       CPU_HAS_ARG, CFG_HAS_ARG;
  logic       CPU_DONE, CFG_DONE;
  logic [1:0] CPU_ERR, CFG_ERR;
  logic       LINK_OWNED, SEND_BYTE, READ_ENABLE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT, BYTE_READY;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;

  mouse_cmd_scheduler #(.ACK_TIMEOUT(ACK_TO), .MAX_RETRIES(3)) dut (
    .CLK(clk), .RESET(RESET),
    .CPU_REQ(CPU_REQ), .CFG_REQ(CFG_REQ),
    .CPU_CMD(CPU_CMD), .CFG_CMD(CFG_CMD),
    .CPU_ARG(CPU_ARG), .CFG_ARG(CFG_ARG),
    .CPU_HAS_ARG(CPU_HAS_ARG), .CFG_HAS_ARG(CFG_HAS_ARG),
    .CPU_DONE(CPU_DONE), .CFG_DONE(CFG_DONE),
    .CPU_ERR(CPU_ERR), .CFG_ERR(CFG_ERR),
    .LINK_OWNED(LINK_OWNED), .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND),
    .BYTE_SENT(BYTE_SENT), .READ_ENABLE(READ_ENABLE),
    .BYTE_READ(BYTE_READ), .BYTE_ERROR_CODE(BYTE_ERROR_CODE), .BYTE_READY(BYTE_READY)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  sb_item_t   sb[$];
  tok_t       dev_q[$];
  tok_t       tok_cpu[$];
  tok_t       tok_cfg[$];
  logic [7:0] act_bytes[$];
  bit         last_cfg = 1'b0;
  int         cpu_done_cnt = 0;
  int         cfg_done_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Reference model: walks the command/argument protocol over the device script.
  task automatic model_txn(input bit is_cfg, input logic [7:0] cmd, input logic [7:0] arg,
                           input bit has);
    sb_item_t it;
    int   retries = 0;
    bit   ph = 1'b0;
    int   idx = 0;
    bit   done = 1'b0;
    tok_t t;
    it.is_cfg = is_cfg;
    it.err    = 2'b00;
    it.kind   = K_BYTE;
    it.nbytes = 0;
    it.bytes  = '0;
    while (!done) begin
      t = is_cfg ? tok_cfg[idx] : tok_cpu[idx];
      idx++;
      dev_q.push_back(t);
      it.bytes[it.nbytes*8 +: 8] = ph ? arg : cmd;
      it.nbytes++;
      case (t)
        T_NOSENT: begin it.err = 2'b01; it.kind = K_SENT_TO; done = 1'b1; end
        T_SILENT: begin it.err = 2'b01; it.kind = K_ACK_TO; done = 1'b1; end
        T_RESEND, T_BADFRAME: begin
          if (retries < 3) retries++;
          else begin it.err = 2'b11; done = 1'b1; end
        end
        T_DEVERR: begin it.err = 2'b10; done = 1'b1; end
        default: begin
          if (!ph && has) begin ph = 1'b1; retries = 0; end
          else begin it.err = 2'b00; done = 1'b1; end
        end
      endcase
    end
    sb.push_back(it);
  endtask

  task automatic serve(input bit cpu_on, input bit cfg_on);
    int c0, f0, budget;
    bit pend_cpu, pend_cfg, first_cfg;
    first_cfg = cfg_on && (!cpu_on || !last_cfg);
    if (first_cfg) begin
      model_txn(1'b1, CFG_CMD, CFG_ARG, CFG_HAS_ARG);
      if (cpu_on) model_txn(1'b0, CPU_CMD, CPU_ARG, CPU_HAS_ARG);
    end else begin
      model_txn(1'b0, CPU_CMD, CPU_ARG, CPU_HAS_ARG);
      if (cfg_on) model_txn(1'b1, CFG_CMD, CFG_ARG, CFG_HAS_ARG);
    end
    last_cfg = (cpu_on && cfg_on) ? !first_cfg : cfg_on;
    c0 = cpu_done_cnt;
    f0 = cfg_done_cnt;
    pend_cpu = cpu_on;
    pend_cfg = cfg_on;
    CPU_REQ = cpu_on;
    CFG_REQ = cfg_on;
    budget = 0;
    while ((pend_cpu || pend_cfg) && budget < 3000) begin
      @(posedge clk); #1;
      budget++;
      if (pend_cpu && cpu_done_cnt != c0) begin CPU_REQ = 1'b0; pend_cpu = 1'b0; end
      if (pend_cfg && cfg_done_cnt != f0) begin CFG_REQ = 1'b0; pend_cfg = 1'b0; end
    end
    if (pend_cpu || pend_cfg) begin
      checks++;
      failures++;
      $display("FAIL serve_timeout got=no_done want=done (cpu=%0b cfg=%0b)", pend_cpu, pend_cfg);
      CPU_REQ = 1'b0;
      CFG_REQ = 1'b0;
      finish_run();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_send_byte"}, SEND_BYTE, 0);
    check({tag, "_read_enable"}, READ_ENABLE, 0);
    check({tag, "_link_owned"}, LINK_OWNED, 0);
    check({tag, "_dones"}, {CPU_DONE, CFG_DONE}, 0);
    check({tag, "_errs"}, {CPU_ERR, CFG_ERR}, 0);
    check({tag, "_byte_to_send"}, BYTE_TO_SEND, 0);
  endtask

  function automatic tok_t rand_tok();
    int r;
    r = $urandom_range(0, 99);
    if (r < 55) return T_ACK;
    if (r < 70) return T_RESEND;
    if (r < 78) return T_BADFRAME;
    if (r < 85) return T_DEVERR;
    if (r < 93) return T_STRAY;
    if (r < 97) return T_SILENT;
    return T_NOSENT;
  endfunction

  // Device model: one script token consumed per transmitted byte.
  task automatic dev_pulse(input logic [7:0] b, input logic [1:0] e);
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #1;
    BYTE_READ = b;
    BYTE_ERROR_CODE = e;
    BYTE_READY = 1'b1;
    @(posedge clk); #1;
    BYTE_READY = 1'b0;
    BYTE_ERROR_CODE = 2'b00;
  endtask

  tok_t dev_tok;
  initial begin
    BYTE_SENT = 1'b0;
    BYTE_READY = 1'b0;
    BYTE_READ = 8'h00;
    BYTE_ERROR_CODE = 2'b00;
    forever begin
      @(negedge clk);
      if (SEND_BYTE) begin
        check("dev_script_available", dev_q.size() > 0, 1);
        dev_tok = (dev_q.size() > 0) ? dev_q.pop_front() : T_SILENT;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        if (dev_tok != T_NOSENT) begin
          BYTE_SENT = 1'b1;
          @(posedge clk); #1;
          BYTE_SENT = 1'b0;
        end
        case (dev_tok)
          T_ACK:      dev_pulse(8'hFA, 2'b00);
          T_RESEND:   dev_pulse(8'hFE, 2'b00);
          T_BADFRAME: dev_pulse(8'hFA, 2'($urandom_range(1, 3)));
          T_DEVERR:   dev_pulse(8'hFC, 2'b00);
          T_STRAY: begin
            dev_pulse(8'h08, 2'b00);
            dev_pulse(8'hFA, 2'b00);
          end
          default: ;
        endcase
      end
    end
  end

  // Monitor: gathers transmitted bytes and scores each DONE against the queue.
  bit       prev_re = 1'b0;
  bit       prev_sent = 1'b0;
  int       last_rdy_cyc = 0;
  int       re_rise_cyc = 0;
  int       last_send_cyc = 0;
  sb_item_t mon_it;
  logic [63:0] packed_bytes;
  int       exp_cyc;
  initial forever begin
    @(negedge clk);
    if (SEND_BYTE) begin
      act_bytes.push_back(BYTE_TO_SEND);
      last_send_cyc = cyc;
      check("owned_at_send", LINK_OWNED, 1);
    end
    if (READ_ENABLE && !prev_re) begin
      re_rise_cyc = cyc;
      check("read_enable_after_sent", prev_sent, 1);
      check("owned_in_wait_ack", LINK_OWNED, 1);
    end
    if (BYTE_READY) last_rdy_cyc = cyc;
    if (CPU_DONE || CFG_DONE) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done got=cpu%0b_cfg%0b want=none", CPU_DONE, CFG_DONE);
      end else begin
        mon_it = sb.pop_front();
        check("done_requester", {CPU_DONE, CFG_DONE}, mon_it.is_cfg ? 2'b01 : 2'b10);
        check("done_err", mon_it.is_cfg ? CFG_ERR : CPU_ERR, mon_it.err);
        check("sent_count", act_bytes.size(), mon_it.nbytes);
        packed_bytes = '0;
        for (int i = 0; i < act_bytes.size() && i < 8; i++) packed_bytes[i*8 +: 8] = act_bytes[i];
        check("sent_bytes", packed_bytes, mon_it.bytes);
        case (mon_it.kind)
          K_ACK_TO:  exp_cyc = re_rise_cyc + ACK_TO;
          K_SENT_TO: exp_cyc = last_send_cyc + ACK_TO + 1;
          default:   exp_cyc = last_rdy_cyc + 1;
        endcase
        check("done_timing", cyc, exp_cyc);
        check("owned_at_report", LINK_OWNED, 1);
      end
      act_bytes.delete();
      if (CPU_DONE) cpu_done_cnt++;
      if (CFG_DONE) cfg_done_cnt++;
    end
    prev_re = READ_ENABLE;
    prev_sent = BYTE_SENT;
  end

  initial begin
    int budget;
    int n_sends;
    int sel;
    RESET = 1'b1;
    CPU_REQ = 1'b0; CFG_REQ = 1'b0;
    CPU_CMD = 8'h00; CFG_CMD = 8'h00; CPU_ARG = 8'h00; CFG_ARG = 8'h00;
    CPU_HAS_ARG = 1'b0; CFG_HAS_ARG = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    RESET = 1'b0;
    @(posedge clk); #1;

    // Simultaneous requests straight after reset: CFG first, then CPU.
    CPU_CMD = 8'hF4; CPU_HAS_ARG = 1'b0;
    CFG_CMD = 8'hE8; CFG_ARG = 8'h02; CFG_HAS_ARG = 1'b1;
    tok_cpu.delete(); tok_cpu.push_back(T_ACK);
    tok_cfg.delete(); tok_cfg.push_back(T_ACK); tok_cfg.push_back(T_ACK);
    serve(1'b1, 1'b1);
    serve(1'b1, 1'b1);

    CPU_CMD = 8'hF4; CPU_HAS_ARG = 1'b0;
    tok_cpu.delete(); tok_cpu.push_back(T_ACK);
    serve(1'b1, 1'b0);

    CFG_CMD = 8'hF3; CFG_ARG = 8'd200; CFG_HAS_ARG = 1'b1;
    tok_cfg.delete(); tok_cfg.push_back(T_ACK); tok_cfg.push_back(T_ACK);
    serve(1'b0, 1'b1);

    // After a lone CFG grant, a tie goes to CPU.
    tok_cpu.delete(); tok_cpu.push_back(T_ACK);
    tok_cfg.delete(); tok_cfg.push_back(T_ACK); tok_cfg.push_back(T_ACK);
    serve(1'b1, 1'b1);

    CPU_CMD = 8'hFF;
    tok_cpu.delete(); repeat (4) tok_cpu.push_back(T_RESEND);
    serve(1'b1, 1'b0);

    tok_cpu.delete(); tok_cpu.push_back(T_STRAY);
    serve(1'b1, 1'b0);

    tok_cpu.delete(); tok_cpu.push_back(T_SILENT);
    serve(1'b1, 1'b0);

    tok_cfg.delete(); tok_cfg.push_back(T_NOSENT);
    serve(1'b0, 1'b1);

    tok_cpu.delete(); tok_cpu.push_back(T_DEVERR);
    serve(1'b1, 1'b0);

    // Reset while waiting for the acknowledge.
    CPU_CMD = 8'hF4; CPU_HAS_ARG = 1'b0;
    dev_q.push_back(T_SILENT);
    CPU_REQ = 1'b1;
    budget = 0;
    while (!READ_ENABLE && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!READ_ENABLE) begin
      checks++;
      failures++;
      $display("FAIL wait_ack_entry got=no_read_enable want=read_enable");
      finish_run();
    end
    repeat (3) @(posedge clk);
    #1;
    RESET = 1'b1;
    CPU_REQ = 1'b0;
    @(posedge clk); #1;
    RESET = 1'b0;
    check_idle_outputs("mid_reset");
    act_bytes.delete();
    last_cfg = 1'b0;
    n_sends = 0;
    repeat (ACK_TO + 20) begin
      @(posedge clk); #1;
      if (SEND_BYTE) n_sends++;
    end
    check("no_send_after_reset", n_sends, 0);

    tok_cpu.delete(); tok_cpu.push_back(T_ACK);
    serve(1'b1, 1'b0);

    for (int n = 0; n < 30; n++) begin
      sel = $urandom_range(1, 3);
      CPU_CMD = 8'($urandom); CPU_ARG = 8'($urandom); CPU_HAS_ARG = 1'($urandom_range(0, 1));
      CFG_CMD = 8'($urandom); CFG_ARG = 8'($urandom); CFG_HAS_ARG = 1'($urandom_range(0, 1));
      tok_cpu.delete();
      tok_cfg.delete();
      repeat (8) begin
        tok_cpu.push_back(rand_tok());
        tok_cfg.push_back(rand_tok());
      end
      serve(sel[0], sel[1]);
    end

    check("scoreboard_drained", sb.size(), 0);
    finish_run();
  end

endmodule
